// File: rtl/gcd_client.sv
// gcd_client: host-side val/rdy initiator that feeds one operand pair at a time to the GCD unit.
// Optional result-wait timeout is compiled in with GCD_CLIENT_TIMEOUT_EN.
module gcd_client #(
  parameter int W       = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic             operands_val,
  input  logic             operands_rdy,
  output logic [W-1:0]     operands_bits_A,
  output logic [W-1:0]     operands_bits_B,
  input  logic             result_val,
  output logic             result_rdy,
  input  logic [W-1:0]     result_bits,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [W-1:0]     resp_bits,
  output logic             resp_timeout,
  output logic [CNT_W-1:0] txn_count
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("gcd_client: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     res_q;
  logic             to_q;
  logic [CNT_W-1:0] cnt_q;
  logic             time_up;

`ifdef GCD_CLIENT_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer;

  // Held at zero while SEND so it starts from zero on the first WAIT cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (state == SEND) begin
      timer <= '0;
    end else if (state == WAIT && !result_val) begin
      timer <= timer + 1'b1;
    end
  end

  assign time_up = (timer == TW'(TIMEOUT - 1));
`else
  assign time_up = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cmd_rdy      = 1'b0;
    operands_val = 1'b0;
    result_rdy   = 1'b0;
    resp_val     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) state_nxt = SEND;
      end
      SEND: begin
        operands_val = 1'b1;
        if (operands_rdy) state_nxt = WAIT;
      end
      WAIT: begin
        result_rdy = 1'b1;
        if (result_val || time_up) state_nxt = RESP;
      end
      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      to_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (state == IDLE && cmd_val) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
      end
      // A real result on the deadline cycle beats the timeout
      if (state == WAIT) begin
        if (result_val) begin
          res_q <= result_bits;
          to_q  <= 1'b0;
        end else if (time_up) begin
          res_q <= '0;
          to_q  <= 1'b1;
        end
      end
      if (state == RESP && resp_rdy) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign operands_bits_A = a_q;
  assign operands_bits_B = b_q;
  assign resp_bits       = res_q;
  assign resp_timeout    = to_q;
  assign txn_count       = cnt_q;

endmodule
